ifid_hazard_ctl: RTL and testbench
==================================

Name: ifid_hazard_ctl

Overview:
- Consumer and controller on the far side of the instruction-fetch interface.
- Latches the fetched instruction and PC+1 into the IF/ID pipeline register.
- Resolves beq/bne/j in the ID stage and detects load-use hazards.
- Drives the fetch-stage control inputs: pcsrc, pcwrite, freeze, addresult.
- Sits between the fetch stage and ID/EX; also supplies register-file read indices.

Parameters:
- AW, 8, PC/instruction-address width (word addressed).
- IW, 32, instruction width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- inst  in  IW  instruction from fetch stage.
- pcadd  in  AW  PC+1 from fetch stage.
- rs_val  in  32  register-file read data for ID rs.
- rt_val  in  32  register-file read data for ID rt.
- idex_memread  in  1  instruction in EX is lw.
- idex_rt  in  5  destination register of the EX-stage lw.
- halt_req  in  1  external halt request, level.
- id_rs  out  5  ifid_inst[25:21].
- id_rt  out  5  ifid_inst[20:16].
- ifid_inst  out  IW  IF/ID instruction register.
- ifid_pc1  out  AW  IF/ID PC+1 register.
- idex_bubble  out  1  force control signals of ID/EX to zero this cycle.
- pcsrc  out  1  redirect fetch to addresult.
- addresult  out  AW  redirect target.
- pcwrite  out  1  fetch PC update enable.
- freeze  out  1  pipeline frozen (HALT).
- stall_cnt  out  16  stall statistics (see Optional Feature).

Behaviour:
- Reset values: ifid_inst=0 (NOP), ifid_pc1=0, state=RUN, stall_cnt=0.
- Reset drives the combinational outputs to: pcsrc=0, pcwrite=1, freeze=0, idex_bubble=0, addresult=0.
- Decode is on ifid_inst[31:26]:
  - 000100 beq: taken when rs_val==rt_val.
  - 000101 bne: taken when rs_val!=rt_val.
  - 000010 j: always taken.
  - All other opcodes: not a branch.
- Branch target = ifid_pc1 + ifid_inst[AW-1:0], modulo 2^AW (wraps, e.g. 0xFF+0x02=0x01).
- Jump target = ifid_inst[AW-1:0].
- hazard = idex_memread && idex_rt!=0 && (idex_rt==id_rs || idex_rt==id_rt).
- FSM states: RUN, STALL, FLUSH, HALT. Priority per cycle: halt_req > hazard > taken branch.
- RUN:
  - halt_req -> HALT.
  - Else if hazard: pcwrite=0, idex_bubble=1, IF/ID holds, -> STALL.
  - Else if taken: pcsrc=1, addresult=target, pcwrite=1, IF/ID loads NOP (0), ifid_pc1 loads 0, -> FLUSH.
  - Else: IF/ID loads inst/pcadd.
- STALL: lasts exactly 1 cycle of hold. Hazard is re-evaluated, since idex_memread is now from the bubble. Then behaves as RUN; a pending branch resolves in this cycle.
- FLUSH: IF/ID holds NOP, so no branch can be taken. Loads inst/pcadd (fetched from target), -> RUN.
- HALT:
  - freeze=1, pcwrite=0, idex_bubble=1, IF/ID holds.
  - On halt_req deassert -> RUN next cycle with the held IF/ID contents.
  - A branch held in IF/ID is resolved after resume.
- pcsrc is asserted only in cycles where pcwrite=1.
- addresult is 0 when pcsrc=0.
- Reset asserted mid-stall or mid-halt: immediate return to reset values; no pending branch survives.

Optional Feature:
- Macro: IFID_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 every cycle in which pcwrite=0 (STALL or HALT). Saturates at 0xFFFF. Cleared only by reset.
- Undefined: no counter logic; stall_cnt tied to 0.

Test Plan:
- Reset then inst=0x20010005, pcadd=0x01 -> next cycle ifid_inst=0x20010005, ifid_pc1=0x01, pcwrite=1, pcsrc=0.
- Load-use: ifid_inst=0x00221820 (add $3,$1,$2), idex_memread=1, idex_rt=1 -> pcwrite=0, idex_bubble=1 for 1 cycle, IF/ID held, then RUN.
- Taken beq: ifid_inst=0x10220003, ifid_pc1=0x10, rs_val=rt_val=7 -> pcsrc=1, addresult=0x13, next ifid_inst=0, then target instruction.
- Target wrap: bne with ifid_pc1=0xFE, imm=0x0004, rs_val=1, rt_val=2 -> addresult=0x02.
- halt_req high for 3 cycles during beq in ID -> freeze=1, pcwrite=0 for 3 cycles, pcsrc=0. After release, branch resolves. With IFID_STALL_CNT_EN, stall_cnt=3.
- rst_n pulsed low during HALT -> all outputs return to reset values asynchronously; state=RUN on release.

Source files
------------

// File: rtl/ifid_fetch_if.sv
// Fetch-stage <-> IF/ID controller interface: fetched word and PC+1 in,
// PC control (redirect, write enable, freeze) out.
interface ifid_fetch_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned IW = 32
);
  logic [IW-1:0] inst;
  logic [AW-1:0] pcadd;
  logic          pcsrc;
  logic [AW-1:0] addresult;
  logic          pcwrite;
  logic          freeze;

  modport master (output inst, pcadd, input pcsrc, addresult, pcwrite, freeze);
  modport slave  (input inst, pcadd, output pcsrc, addresult, pcwrite, freeze);
endinterface

// File: rtl/ifid_hazard_ctl.sv
// IF/ID pipeline register with ID-stage branch resolution, load-use stall and halt control.
// Optional stall statistics counter enabled by macro IFID_STALL_CNT_EN.
module ifid_hazard_ctl #(
  parameter int unsigned AW = 8,
  parameter int unsigned IW = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  ifid_fetch_if.slave    fetch,
  input  logic [31:0]    rs_val,
  input  logic [31:0]    rt_val,
  input  logic           idex_memread,
  input  logic [4:0]     idex_rt,
  input  logic           halt_req,
  output logic [4:0]     id_rs,
  output logic [4:0]     id_rt,
  output logic [IW-1:0]  ifid_inst,
  output logic [AW-1:0]  ifid_pc1,
  output logic           idex_bubble,
  output logic [15:0]    stall_cnt
);

  localparam int unsigned OPW = 6;
  localparam logic [OPW-1:0] OP_BEQ = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_J   = OPW'(6'b000010);

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FLUSH, ST_HALT} state_t;
  typedef enum logic [1:0] {LD_HOLD, LD_FETCH, LD_NOP} ld_t;

  state_t        r_state, w_state_nxt;
  ld_t           w_ld;
  logic [IW-1:0] r_inst;
  logic [AW-1:0] r_pc1;
  logic [OPW-1:0] w_op;
  logic          w_taken;
  logic          w_hazard;
  logic [AW-1:0] w_target;
  logic          w_pcsrc;
  logic [AW-1:0] w_addr;
  logic          w_pcwrite;
  logic          w_freeze;
  logic          w_bubble;

  assign w_op   = r_inst[31:26];
  assign id_rs  = r_inst[25:21];
  assign id_rt  = r_inst[20:16];

  assign w_taken = ((w_op == OP_BEQ) && (rs_val == rt_val)) ||
                   ((w_op == OP_BNE) && (rs_val != rt_val)) ||
                   (w_op == OP_J);

  // Jumps use the low address bits directly; branches are PC+1 relative and wrap.
  assign w_target = (w_op == OP_J) ? r_inst[AW-1:0]
                                   : AW'(r_pc1 + r_inst[AW-1:0]);

  assign w_hazard = idex_memread && (idex_rt != 5'd0) &&
                    ((idex_rt == id_rs) || (idex_rt == id_rt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Priority: halt > load-use hazard > taken branch. FLUSH holds a NOP, so it never redirects.
  always_comb begin
    w_state_nxt = ST_RUN;
    w_ld        = LD_FETCH;
    w_pcsrc     = 1'b0;
    w_addr      = '0;
    w_pcwrite   = 1'b1;
    w_freeze    = 1'b0;
    w_bubble    = 1'b0;
    if (!rst_n) begin
      w_ld = LD_HOLD;
    end else if (halt_req) begin
      w_state_nxt = ST_HALT;
      w_ld        = LD_HOLD;
      w_pcwrite   = 1'b0;
      w_freeze    = 1'b1;
      w_bubble    = 1'b1;
    end else if (w_hazard) begin
      w_state_nxt = ST_STALL;
      w_ld        = LD_HOLD;
      w_pcwrite   = 1'b0;
      w_bubble    = 1'b1;
    end else if (w_taken && (r_state != ST_FLUSH)) begin
      w_state_nxt = ST_FLUSH;
      w_ld        = LD_NOP;
      w_pcsrc     = 1'b1;
      w_addr      = w_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst <= '0;
      r_pc1  <= '0;
    end else begin
      case (w_ld)
        LD_FETCH: begin
          r_inst <= fetch.inst;
          r_pc1  <= fetch.pcadd;
        end
        LD_NOP: begin
          r_inst <= '0;
          r_pc1  <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef IFID_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of cycles with the PC held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    r_stall_cnt <= '0;
    else if (!w_pcwrite && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

  assign ifid_inst       = r_inst;
  assign ifid_pc1        = r_pc1;
  assign idex_bubble     = w_bubble;
  assign fetch.pcsrc     = w_pcsrc;
  assign fetch.addresult = w_addr;
  assign fetch.pcwrite   = w_pcwrite;
  assign fetch.freeze    = w_freeze;

endmodule

// File: tb/tb_ifid_hazard_ctl.sv
// Directed bench for ifid_hazard_ctl: vector table plus halt and reset-during-halt sequences.
module tb_ifid_hazard_ctl;

  logic        clk;
  logic        rst_n;
  logic [31:0] rs_val, rt_val;
  logic        idex_memread;
  logic [4:0]  idex_rt;
  logic        halt_req;
  logic [4:0]  id_rs, id_rt;
  logic [31:0] ifid_inst;
  logic [7:0]  ifid_pc1;
  logic        idex_bubble;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int m_stall = 0;

  ifid_fetch_if #(.AW(8), .IW(32)) fif ();

  ifid_hazard_ctl #(.AW(8), .IW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch        (fif),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .halt_req     (halt_req),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ifid_inst    (ifid_inst),
    .ifid_pc1     (ifid_pc1),
    .idex_bubble  (idex_bubble),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [7:0]  pcadd;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        mr;
    logic [4:0]  irt;
    logic        x_pcsrc;
    logic [7:0]  x_addr;
    logic        x_pw;
    logic        x_bub;
    logic [31:0] x_inst;
    logic [7:0]  x_pc1;
  } vec_t;

  vec_t tv[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic pcsrc, input logic [7:0] addr,
                         input logic pw, input logic fz, input logic bub);
    chk({tag, ".pcsrc"},     32'(fif.pcsrc),     32'(pcsrc));
    chk({tag, ".addresult"}, 32'(fif.addresult), 32'(addr));
    chk({tag, ".pcwrite"},   32'(fif.pcwrite),   32'(pw));
    chk({tag, ".freeze"},    32'(fif.freeze),    32'(fz));
    chk({tag, ".bubble"},    32'(idex_bubble),   32'(bub));
  endtask

  function automatic logic [15:0] exp_cnt();
`ifdef IFID_STALL_CNT_EN
    return 16'(m_stall);
`else
    return 16'd0;
`endif
  endfunction

  initial begin
    //        inst          pc     rs  rt  mr irt  pcsrc addr  pw bub  x_inst        x_pc1
    tv[0]  = '{32'h20010005, 8'h01, 0, 0, 0, 0,   0, 8'h00, 1, 0, 32'h20010005, 8'h01};
    tv[1]  = '{32'h00221820, 8'h02, 0, 0, 0, 0,   0, 8'h00, 1, 0, 32'h00221820, 8'h02};
    tv[2]  = '{32'h00000000, 8'h03, 0, 0, 1, 1,   0, 8'h00, 0, 1, 32'h00221820, 8'h02};
    tv[3]  = '{32'h10220003, 8'h10, 0, 0, 0, 0,   0, 8'h00, 1, 0, 32'h10220003, 8'h10};
    tv[4]  = '{32'hAAAA0000, 8'h11, 7, 7, 0, 0,   1, 8'h13, 1, 0, 32'h00000000, 8'h00};
    tv[5]  = '{32'h00000020, 8'h14, 7, 7, 0, 0,   0, 8'h00, 1, 0, 32'h00000020, 8'h14};
    tv[6]  = '{32'h14220004, 8'hFE, 0, 0, 0, 0,   0, 8'h00, 1, 0, 32'h14220004, 8'hFE};
    tv[7]  = '{32'h11111111, 8'hFF, 1, 2, 0, 0,   1, 8'h02, 1, 0, 32'h00000000, 8'h00};
    tv[8]  = '{32'h08000055, 8'h03, 1, 2, 0, 0,   0, 8'h00, 1, 0, 32'h08000055, 8'h03};
    tv[9]  = '{32'h12345678, 8'h04, 0, 0, 0, 0,   1, 8'h55, 1, 0, 32'h00000000, 8'h00};
    tv[10] = '{32'h10220003, 8'h40, 0, 0, 0, 0,   0, 8'h00, 1, 0, 32'h10220003, 8'h40};
    tv[11] = '{32'h00000000, 8'h41, 1, 2, 0, 0,   0, 8'h00, 1, 0, 32'h00000000, 8'h41};
    tv[12] = '{32'h00221820, 8'h42, 0, 0, 1, 0,   0, 8'h00, 1, 0, 32'h00221820, 8'h42};
    tv[13] = '{32'h20010005, 8'h43, 0, 0, 1, 2,   0, 8'h00, 0, 1, 32'h00221820, 8'h42};
    tv[14] = '{32'h20010005, 8'h43, 0, 0, 0, 0,   0, 8'h00, 1, 0, 32'h20010005, 8'h43};

    rst_n = 1'b0; halt_req = 1'b0; idex_memread = 1'b0; idex_rt = 5'd0;
    rs_val = 32'd0; rt_val = 32'd0; fif.inst = 32'h0; fif.pcadd = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ifid_inst", ifid_inst, 32'h0);
    chk("rst.ifid_pc1", 32'(ifid_pc1), 32'h0);
    chk("rst.stall_cnt", 32'(stall_cnt), 32'h0);
    chk_ctl("rst", 0, 8'h00, 1, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      fif.inst = tv[i].inst; fif.pcadd = tv[i].pcadd;
      rs_val = tv[i].rs; rt_val = tv[i].rt;
      idex_memread = tv[i].mr; idex_rt = tv[i].irt;
      #1;
      chk_ctl($sformatf("vec%0d", i), tv[i].x_pcsrc, tv[i].x_addr, tv[i].x_pw, 1'b0, tv[i].x_bub);
      if (!tv[i].x_pw) m_stall++;
      @(posedge clk); #1;
      chk($sformatf("vec%0d.ifid_inst", i), ifid_inst, tv[i].x_inst);
      chk($sformatf("vec%0d.ifid_pc1", i), 32'(ifid_pc1), 32'(tv[i].x_pc1));
      if (i == 1) begin
        chk("vec1.id_rs", 32'(id_rs), 32'd1);
        chk("vec1.id_rt", 32'(id_rt), 32'd2);
      end
    end
    chk("vec.stall_cnt", 32'(stall_cnt), 32'(exp_cnt()));

    // Halt for three cycles with a taken beq sitting in ID.
    idex_memread = 1'b0; idex_rt = 5'd0; rs_val = 32'd0; rt_val = 32'd0;
    fif.inst = 32'h10220003; fif.pcadd = 8'h10;
    @(posedge clk); #1;
    chk("halt.load_beq", ifid_inst, 32'h10220003);
    rs_val = 32'd7; rt_val = 32'd7; halt_req = 1'b1;
    fif.inst = 32'hDEAD0000; fif.pcadd = 8'h11;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_ctl($sformatf("halt%0d", k), 0, 8'h00, 0, 1, 1);
      m_stall++;
      @(posedge clk); #1;
      chk($sformatf("halt%0d.hold", k), ifid_inst, 32'h10220003);
    end
    halt_req = 1'b0;
    #1;
    chk_ctl("resume", 1, 8'h13, 1, 0, 0);
    @(posedge clk); #1;
    chk("resume.flush", ifid_inst, 32'h0);
    chk("halt.stall_cnt", 32'(stall_cnt), 32'(exp_cnt()));

    // Reset pulsed while halted with a branch pending.
    fif.inst = 32'h10220003; fif.pcadd = 8'h10;
    @(posedge clk); #1;
    halt_req = 1'b1;
    m_stall++;
    @(posedge clk); #1;
    chk("prerst.hold", ifid_inst, 32'h10220003);
    #2 rst_n = 1'b0;
    #1;
    m_stall = 0;
    chk("rsthalt.ifid_inst", ifid_inst, 32'h0);
    chk("rsthalt.ifid_pc1", 32'(ifid_pc1), 32'h0);
    chk("rsthalt.stall_cnt", 32'(stall_cnt), 32'h0);
    chk_ctl("rsthalt", 0, 8'h00, 1, 0, 0);
    halt_req = 1'b0;
    #1 rst_n = 1'b1;
    fif.inst = 32'h20010005; fif.pcadd = 8'h05;
    #1;
    chk_ctl("postrst", 0, 8'h00, 1, 0, 0);
    @(posedge clk); #1;
    chk("postrst.ifid_inst", ifid_inst, 32'h20010005);
    chk("postrst.ifid_pc1", 32'(ifid_pc1), 32'h05);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
